mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fully pipelined, fixed-latency data/instruction memory between two requesters: instruction fetch (IF, read-only) and load/store (LSU, read/write).
- Sits between the fetch/memory-access stages and the unified memory.
- Issues combinational grants, routes each read response back to its originator, and drops stale fetch responses on a pipeline redirect.

Parameters:
- AW, 32, address width in bits (data width fixed at 32).
- LAT, 1, memory read latency in cycles, from accepted request to mem_rdata valid; legal 1..4.
- BURST_MAX, 4, maximum consecutive grants to one requester while the other is waiting; legal 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_flush  in  1  kill all previously accepted, not-yet-returned fetch reads
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- lsu_req  in  1  LSU request
- lsu_we  in  4  byte write strobes; 0 = read
- lsu_addr  in  AW  LSU address
- lsu_wdata  in  32  LSU write data
- lsu_gnt  out  1  LSU request accepted this cycle (combinational)
- lsu_rvalid  out  1  LSU read data valid (reads only)
- lsu_rdata  out  32  LSU read data
- mem_en  out  1  memory access strobe
- mem_we  out  4  memory byte write enables
- mem_addr  out  AW  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid LAT cycles after mem_en
- perf_conflict_cnt  out  32  cycles with both requesters asserting req
- perf_if_stall_cnt  out  32  cycles with if_req=1 and if_gnt=0

Behaviour:
- Handshake: a request is accepted when req=1 and gnt=1 in the same cycle. The requester holds addr/we/wdata stable until accepted. At most one grant per cycle.
- Grant selection:
  - Only one requester asserting req: that requester is granted.
  - Neither asserting: no grant; mem_en=0, mem_we=0.
  - Both asserting (contention): grant last_gnt if run_cnt < BURST_MAX, otherwise the other requester.
- State update on each accept:
  - Same requester as last_gnt: run_cnt saturates-increments.
  - Different requester: last_gnt switches and run_cnt=1.
  - Cycles without an accept leave both unchanged.
- Memory outputs are a combinational mux of the granted requester's fields; there is no added latency.
  - IF grant drives mem_we=0.
  - When nothing is granted, mem_addr/mem_wdata are don't-care.
- Response pipeline: a LAT-deep shift register of {valid, id, live}, pushed each cycle with the accept of a read (LSU writes push valid=0).
  - At the tail, for an IF entry: if_rvalid = valid & live.
  - At the tail, for an LSU entry: lsu_rvalid = valid.
  - if_rdata and lsu_rdata pass mem_rdata through directly.
- Ordering: responses return in acceptance order. rvalid occurs exactly LAT cycles after the accept cycle.
- Flush:
  - if_flush clears live on every IF entry already in the pipeline, including the entry at the tail that cycle, whose if_rvalid is suppressed.
  - An IF request accepted in the same cycle as if_flush is not killed.
  - LSU entries are unaffected.
- Reset (rst=0, asynchronous):
  - last_gnt=IF, run_cnt=0, all pipeline valid bits cleared, perf counters cleared.
  - if_rvalid=0 and lsu_rvalid=0.
  - Grants and mem_* remain combinational; all mem_en/mem_we/gnt outputs are forced to 0 while rst=0.
  - Reads in flight at reset never produce rvalid.
- Perf counters wrap modulo 2^32.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined: perf_conflict_cnt and perf_if_stall_cnt count as described above.
- Undefined: both outputs are tied to 32'd0 and the counter flops are absent. All other behaviour is identical.

Decomposition:
- Shared defines header:
  - requester ID constants MEM_ARB_ID_IF=1'b0, MEM_ARB_ID_LSU=1'b1
  - byte-strobe width constant (4)
- Sub-module mem_arb_rsp_pipe: the LAT-deep {valid, id, live} shift register with flush input. Instantiated once.

Test Plan:
- Reset, then IF-only reads at 0x0, 0x4, 0x8 on consecutive cycles, LAT=1 → if_gnt=1 each cycle; if_rvalid at cycles 1, 2, 3 with the memory words for those addresses; lsu_rvalid=0.
- Both requesters held continuously, BURST_MAX=4 → grant sequence IF,IF,IF,IF,LSU,LSU,LSU,LSU,IF…; perf_conflict_cnt increments every cycle.
- LSU write lsu_we=4'b0011, addr 0x100, wdata 0xDEADBEEF, then LSU read 0x100 → mem_we=4'b0011 on the write; no lsu_rvalid for the write; the read returns 0x0000BEEF-merged word after LAT cycles.
- LAT=3, IF reads accepted at cycles 0, 1, 2, if_flush at cycle 2 → only the cycle-2 read returns (if_rvalid at cycle 5); cycles 3 and 4 show no if_rvalid.
- IF read in flight at LAT=2 with an interleaved LSU read, then rst pulsed low mid-flight → no rvalid after reset; first contention after reset is granted to IF.
- Build without MEM_ARB_PERF_CNT_EN under the contention stimulus → both perf outputs read 0; grant sequence unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/LSU memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DW     = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned RUN_W  = 4;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic {
    MEM_ARB_ID_IF  = 1'b0,
    MEM_ARB_ID_LSU = 1'b1
  } mem_arb_id_e;

  typedef struct packed {
    logic        valid;
    mem_arb_id_e id;
    logic        live;
  } rsp_ent_t;

  // Clear the live bit of a fetch entry when a redirect flush is seen.
  function automatic rsp_ent_t rsp_kill(input rsp_ent_t e, input logic flush);
    rsp_ent_t r;
    r = e;
    if (flush && (e.id == MEM_ARB_ID_IF)) r.live = 1'b0;
    return r;
  endfunction

  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
    return (v == '1) ? v : v + RUN_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_rsp_pipe.sv
// LAT-deep {valid, id, live} tracker that routes memory read responses back
// to their originator and drops fetch responses killed by a flush.
module mem_arb_rsp_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid,
  input  mem_arb_id_e push_id,
  input  logic        flush,
  output logic        if_rvalid_c,
  output logic        lsu_rvalid_c
);

  rsp_ent_t stage_q [LAT];
  rsp_ent_t push_c;
  rsp_ent_t tail_c;

  always_comb begin
    push_c       = '0;
    push_c.valid = push_valid;
    push_c.id    = push_id;
    push_c.live  = 1'b1;
  end

  for (genvar g = 0; g < int'(LAT); g++) begin : g_stage
    if (g == 0) begin : g_head
      // New entries are never killed by a flush in their own accept cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) stage_q[g] <= '0;
        else      stage_q[g] <= push_c;
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) stage_q[g] <= '0;
        else      stage_q[g] <= rsp_kill(stage_q[g-1], flush);
      end
    end
  end

  // The tail entry is also subject to a flush raised in its return cycle.
  always_comb begin
    tail_c       = rsp_kill(stage_q[LAT-1], flush);
    if_rvalid_c  = tail_c.valid & (tail_c.id == MEM_ARB_ID_IF) & tail_c.live;
    lsu_rvalid_c = tail_c.valid & (tail_c.id == MEM_ARB_ID_LSU);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch, load/store) arbiter in front of a single-port
// fixed-latency memory. Optional perf counters: MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned LAT       = 1,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_gnt,
  input  logic              if_flush,
  output logic              if_rvalid,
  output logic [DW-1:0]     if_rdata,
  input  logic              lsu_req,
  input  logic [STRB_W-1:0] lsu_we,
  input  logic [AW-1:0]     lsu_addr,
  input  logic [DW-1:0]     lsu_wdata,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [DW-1:0]     lsu_rdata,
  output logic              mem_en,
  output logic [STRB_W-1:0] mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [CNT_W-1:0]  perf_conflict_cnt,
  output logic [CNT_W-1:0]  perf_if_stall_cnt
);

  mem_arb_id_e      last_gnt_q;
  logic [RUN_W-1:0] run_cnt_q;
  logic             pick_lsu_c;
  mem_arb_id_e      gnt_id_c;
  logic             push_valid_c;

  // Grant select: lone requester wins; on contention stay with the last
  // winner until it has used up its burst allowance.
  always_comb begin
    pick_lsu_c = 1'b0;
    if (lsu_req && !if_req) begin
      pick_lsu_c = 1'b1;
    end else if (lsu_req && if_req) begin
      if (run_cnt_q < RUN_W'(BURST_MAX)) pick_lsu_c = (last_gnt_q == MEM_ARB_ID_LSU);
      else                               pick_lsu_c = (last_gnt_q == MEM_ARB_ID_IF);
    end
    if_gnt       = rst & if_req & ~pick_lsu_c;
    lsu_gnt      = rst & lsu_req & pick_lsu_c;
    mem_en       = if_gnt | lsu_gnt;
    mem_we       = lsu_gnt ? lsu_we : '0;
    mem_addr     = pick_lsu_c ? lsu_addr : if_addr;
    mem_wdata    = lsu_wdata;
    gnt_id_c     = lsu_gnt ? MEM_ARB_ID_LSU : MEM_ARB_ID_IF;
    push_valid_c = if_gnt | (lsu_gnt & ~(|lsu_we));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q <= MEM_ARB_ID_IF;
      run_cnt_q  <= '0;
    end else if (mem_en) begin
      if (gnt_id_c == last_gnt_q) begin
        run_cnt_q <= run_inc(run_cnt_q);
      end else begin
        last_gnt_q <= gnt_id_c;
        run_cnt_q  <= RUN_W'(1);
      end
    end
  end

  mem_arb_rsp_pipe #(
    .LAT (LAT)
  ) u_rsp_pipe (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid_c),
    .push_id      (gnt_id_c),
    .flush        (if_flush),
    .if_rvalid_c  (if_rvalid),
    .lsu_rvalid_c (lsu_rvalid)
  );

  assign if_rdata  = mem_rdata;
  assign lsu_rdata = mem_rdata;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] conflict_q;
  logic [CNT_W-1:0] if_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= '0;
      if_stall_q <= '0;
    end else begin
      conflict_q <= conflict_q + CNT_W'(if_req & lsu_req);
      if_stall_q <= if_stall_q + CNT_W'(if_req & ~if_gnt);
    end
  end

  assign perf_conflict_cnt = conflict_q;
  assign perf_if_stall_cnt = if_stall_q;
`else
  assign perf_conflict_cnt = '0;
  assign perf_if_stall_cnt = '0;
`endif

endmodule
